// File: rtl/program_loader.sv
// program_loader: boot-time byte-stream loader that assembles little-endian
// words, writes them into RAM from the reset PC upward and then releases the CPU.
module program_loader #(
    parameter int                       ADDRESS_SIZE = 11,
    parameter int                       WORD_SIZE    = 64,
    parameter logic [ADDRESS_SIZE-1:0]  BASE_ADDRESS = 11'h400,
    parameter int                       ADDR_STRIDE  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              inByte,
    input  logic                    inValid,
    output logic                    inReady,
    output logic [ADDRESS_SIZE-1:0] memAddress,
    output logic [WORD_SIZE-1:0]    memData,
    output logic                    memWrite,
    output logic                    cpuRun,
    output logic                    done,
    output logic                    error,
    output logic [15:0]             wordsLoaded
);

    localparam int BYTES_PER_WORD = WORD_SIZE / 8;
    localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_W-1:0]        LAST_BYTE  = CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDRESS_SIZE:0]   STRIDE_EXT = (ADDRESS_SIZE+1)'(ADDR_STRIDE);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } loaderStateT;

    loaderStateT           state;
    loaderStateT           nextState;
    logic [CNT_W-1:0]      byteCount;
    logic [15:0]           remaining;
    logic                  accept;
    logic [ADDRESS_SIZE:0] addrSum;

    assign accept  = inValid && inReady;
    assign addrSum = {1'b0, memAddress} + STRIDE_EXT;

    // Next-state selection; the carry out of the widened address adder flags overflow.
    always_comb begin
        nextState = state;
        case (state)
            S_LEN_LO: begin
                if (accept) nextState = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) nextState = ({inByte, remaining[7:0]} == 16'd0) ? S_DONE : S_DATA;
            end
            S_DATA: begin
                if (accept && byteCount == LAST_BYTE) nextState = S_WRITE;
            end
            S_WRITE: begin
                if (remaining == 16'd1)            nextState = S_DONE;
                else if (addrSum[ADDRESS_SIZE])    nextState = S_ERROR;
                else                               nextState = S_DATA;
            end
            S_DONE:  nextState = S_DONE;
            S_ERROR: nextState = S_ERROR;
            default: nextState = S_LEN_LO;
        endcase
    end

    // State register plus outputs registered from the upcoming state, and the datapath updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_LEN_LO;
            inReady     <= 1'b1;
            memWrite    <= 1'b0;
            memAddress  <= BASE_ADDRESS;
            memData     <= '0;
            cpuRun      <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            wordsLoaded <= 16'd0;
            byteCount   <= '0;
            remaining   <= 16'd0;
        end else begin
            state    <= nextState;
            inReady  <= (nextState == S_LEN_LO) || (nextState == S_LEN_HI) || (nextState == S_DATA);
            memWrite <= (nextState == S_WRITE);
            cpuRun   <= (nextState == S_DONE);
            done     <= (nextState == S_DONE);
            error    <= (nextState == S_ERROR);
            case (state)
                S_LEN_LO: begin
                    if (accept) remaining[7:0] <= inByte;
                end
                S_LEN_HI: begin
                    if (accept) remaining[15:8] <= inByte;
                end
                S_DATA: begin
                    if (accept) begin
                        memData   <= (memData >> 8) | (WORD_SIZE'(inByte) << (WORD_SIZE - 8));
                        byteCount <= (byteCount == LAST_BYTE) ? '0 : byteCount + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    remaining   <= remaining - 16'd1;
                    wordsLoaded <= wordsLoaded + 16'd1;
                    if (nextState == S_DATA) memAddress <= addrSum[ADDRESS_SIZE-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule
